// File: rtl/rr_mux_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin mux arbiter.
// master = arbiter side (drives gnt/sel/busy), slave = requester/mux side.
interface rr_mux_arbiter_if #(
    parameter int N     = 4,
    parameter int SEL_W = 2
);
    logic [N-1:0]     req;
    logic [N-1:0]     gnt;
    logic [SEL_W-1:0] sel;
    logic             busy;

    modport master (input req, output gnt, output sel, output busy);
    modport slave  (output req, input gnt, input sel, input busy);
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving an N:1 mux select; grant is held while the owner requests.
// Define ARB_TIMEOUT_EN to revoke a grant held MAX_HOLD cycles when others are waiting.
module rr_mux_arbiter #(
    parameter int N        = 4,
    parameter int SEL_W    = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic                clk,
    input  logic                rst,
    rr_mux_arbiter_if.master    bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             busy_q, busy_d;

    logic [N-1:0]     owner_oh;
    logic [N-1:0]     cand;
    logic             owner_req;
    logic             revoke;
    logic             rearb;
    logic             win_vld;
    logic [SEL_W-1:0] win;
    logic [SEL_W:0]   idx;

`ifdef ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD);
    logic [HW-1:0] hold_q, hold_d;
    logic          hold_sat;
    assign hold_sat = (hold_q == HW'(MAX_HOLD - 1));
`endif

    // State and all outputs are registered; reset clears them asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= SEL_W'(N - 1);
            busy_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
`ifdef ARB_TIMEOUT_EN
            hold_q  <= hold_d;
`endif
        end
    end

    // Arbitration point: idle, owner released, or owner revoked.
    always_comb begin
        owner_oh        = '0;
        owner_oh[sel_q] = 1'b1;
        owner_req       = (state_q == GRANT) && bus.req[sel_q];
`ifdef ARB_TIMEOUT_EN
        revoke = owner_req && hold_sat && (|(bus.req & ~owner_oh));
`else
        revoke = 1'b0;
`endif
        rearb = !owner_req || revoke;
        cand  = (state_q == GRANT) ? (bus.req & ~owner_oh) : bus.req;

        // Search upward from ptr+1 with wrap; owner sits last so it is never re-picked.
        win_vld = 1'b0;
        win     = '0;
        idx     = '0;
        for (int i = 1; i <= N; i++) begin
            idx = {1'b0, ptr_q} + (SEL_W+1)'(i);
            if (idx >= (SEL_W+1)'(N)) idx = idx - (SEL_W+1)'(N);
            if (!win_vld && cand[idx[SEL_W-1:0]]) begin
                win_vld = 1'b1;
                win     = idx[SEL_W-1:0];
            end
        end

        state_d = state_q;
        if (rearb) state_d = win_vld ? GRANT : IDLE;
    end

    always_comb begin
        gnt_d  = gnt_q;
        sel_d  = sel_q;
        ptr_d  = ptr_q;
        busy_d = busy_q;
`ifdef ARB_TIMEOUT_EN
        hold_d = hold_q;
`endif
        if (rearb && win_vld) begin
            gnt_d      = '0;
            gnt_d[win] = 1'b1;
            sel_d      = win;
            ptr_d      = win;
            busy_d     = 1'b1;
`ifdef ARB_TIMEOUT_EN
            hold_d     = '0;
`endif
        end else if (rearb) begin
            gnt_d  = '0;
            busy_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_d = '0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            if (!hold_sat) hold_d = hold_q + HW'(1);
`endif
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.sel  = sel_q;
    assign bus.busy = busy_q;
endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one N:1 mux datapath between N requesters.
- Drives the mux select from the current grant, holds the grant while the owner keeps requesting, and optionally revokes long-held grants.
- Sits directly in front of the mux_p-family select inputs.
- Fully registered outputs; one clock domain.

Parameters:
- N, 4, number of requesters; legal range 2..16.
- SEL_W, 2, select width; must equal clog2(N).
- MAX_HOLD, 8, maximum consecutive grant cycles before forced re-arbitration; legal when ≥2; used only with the optional feature.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  level request per requester; bit i belongs to requester i.
- gnt  output  N  one-hot registered grant; all zero when idle.
- sel  output  SEL_W  registered index of the granted requester; drives the mux select.
- busy  output  1  high whenever any gnt bit is high.

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-high on rst.
- While rst is high, state and outputs clear immediately without waiting for clk:
  - gnt=0, sel=0, busy=0.
  - Last-grantee pointer ptr=N-1, so requester 0 wins first.
  - hold_cnt=0.
  - State=IDLE.
- States: IDLE and GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise choose the winner w = the first set req bit searching upward from (ptr+1) mod N, wrapping.
  - Next edge: gnt=onehot(w), sel=w, busy=1, ptr=w, hold_cnt=0, state=GRANT.
  - Latency from req asserted to gnt asserted is 1 cycle.
- GRANT while req[sel]=1 (and no revoke): hold gnt/sel; hold_cnt increments and saturates at MAX_HOLD-1.
- GRANT when req[sel]=0 (release):
  - In the same cycle, arbitrate among the remaining requests starting after ptr.
  - If any remain: next edge grants the new winner directly, with no idle bubble; hold_cnt=0.
  - If none remain: next edge gnt=0, busy=0, state=IDLE; sel keeps its last value.
- Grant changes occur only on clock edges. gnt is never multi-hot, and never glitches between one-hot values within a cycle.
- Request rules:
  - Requests are level-sensitive and not latched.
  - A requester that drops req before being granted loses its turn with no side effects.
  - Requesting bits not currently granted are ignored until the next arbitration point.
- Fairness: with all N requesting continuously, grants rotate 0,1,..,N-1,0.
- Simultaneous events:
  - Release and revoke in the same cycle are treated as a release.
  - With a single requester, the grant is never revoked.
- Reset mid-GRANT: gnt drops asynchronously with rst. After reset, requester 0 has first priority again.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined (revoke enabled):
  - Revoke occurs when state=GRANT, hold_cnt==MAX_HOLD-1, req[sel]=1, and any other req bit is set.
  - On revoke, the next edge grants the next round-robin winner, excluding the current owner, with hold_cnt=0.
  - The revoked requester may win again later by rotation.
  - If no other requester is pending, the grant is held and hold_cnt stays saturated.
- Not defined: no revoke; the grant is held until release. hold_cnt logic may be omitted, and MAX_HOLD is ignored.

Test Plan:
- Reset values (N=4): drive rst=1 mid-simulation with req=4'b1111 -> gnt=0000, sel=0, busy=0 immediately, without waiting for clk. After rst falls, the first grant is gnt=0001.
- Single request: req=0100 from IDLE -> gnt=0100, sel=2, busy=1 exactly one edge later. Drop req -> gnt=0000, busy=0 one edge later.
- Rotation with 2-cycle holds:
  - Stimulus: req=1111 with each owner dropping its bit after 2 granted cycles and re-raising it one cycle later.
  - Required: sel sequence 0,1,2,3,0; no gnt=0000 cycle between owners.
- Handoff, no bubble: owner 1 granted with req=1010; drop req[1] -> next edge gnt=1000, sel=3, busy held at 1 throughout.
- Timeout, ARB_TIMEOUT_EN with MAX_HOLD=8:
  - Owner 0 holds req with req=0011 -> gnt=0010 after exactly 8 granted cycles.
  - With req=0001 only, gnt=0001 persists for more than 20 cycles.
  - Without the macro, gnt=0001 persists with req=0011 for more than 20 cycles.
- Reset mid-grant: owner 3 granted, assert rst between edges -> gnt=0000 at once. After release with req=1001, the first grant is gnt=0001 (ptr reset).
